// File: rtl/pwm_channel_controller.sv
// 16-pin PWM channel controller: shared prescaler, period counter and duty.
// Define PWM_SYNC_UPDATE_EN to defer configuration changes to period wrap.
module pwm_channel_controller #(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] en_out,
   input  logic [15:0] en_pwm,
   input  logic [7:0]  duty,
   output logic [15:0] pins,
   output logic        period_start,
   output logic        cfg_pending
);

   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

   logic [15:0] psc_q, psc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ps_q, ps_d;
   logic [15:0] pins_q, pins_d;
   logic [15:0] act_out_q, act_out_d;
   logic [15:0] act_pwm_q, act_pwm_d;
   logic [7:0]  act_duty_q, act_duty_d;
   logic        pend_q, pend_d;
   logic        tick;
   logic        wrap;
   logic        load;
   logic        level;

   assign tick = (psc_q == DIV_M1);
   assign wrap = tick && (cnt_q == 8'hFF);

   always_comb begin
      psc_d = tick ? 16'd0 : psc_q + 16'd1;
      cnt_d = tick ? cnt_q + 8'd1 : cnt_q;
      ps_d  = wrap;
   end

`ifdef PWM_SYNC_UPDATE_EN
   logic cfg_diff;

   assign cfg_diff = (en_out != act_out_q) ||
                     (en_pwm != act_pwm_q) ||
                     (duty != act_duty_q);
   assign load = wrap;

   always_comb begin
      pend_d = pend_q;
      if (wrap) begin
         pend_d = 1'b0;
      end else if (cfg_diff) begin
         pend_d = 1'b1;
      end
   end
`else
   assign load   = 1'b1;
   assign pend_d = 1'b0;
`endif

   always_comb begin
      act_out_d  = act_out_q;
      act_pwm_d  = act_pwm_q;
      act_duty_d = act_duty_q;
      if (load) begin
         act_out_d  = en_out;
         act_pwm_d  = en_pwm;
         act_duty_d = duty;
      end
   end

   // 0xFF is special-cased so full duty never drops at cnt==255
   always_comb begin
      level = 1'b0;
      if (act_duty_q == 8'hFF) begin
         level = 1'b1;
      end else begin
         level = (cnt_q < act_duty_q);
      end
   end

   always_comb begin
      pins_d = '0;
      for (int i = 0; i < 16; i++) begin
         pins_d[i] = act_out_q[i] & (~act_pwm_q[i] | level);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q      <= '0;
         cnt_q      <= '0;
         ps_q       <= 1'b0;
         pins_q     <= '0;
         act_out_q  <= '0;
         act_pwm_q  <= '0;
         act_duty_q <= '0;
         pend_q     <= 1'b0;
      end else begin
         psc_q      <= psc_d;
         cnt_q      <= cnt_d;
         ps_q       <= ps_d;
         pins_q     <= pins_d;
         act_out_q  <= act_out_d;
         act_pwm_q  <= act_pwm_d;
         act_duty_q <= act_duty_d;
         pend_q     <= pend_d;
      end
   end

   assign pins         = pins_q;
   assign period_start = ps_q;
   assign cfg_pending  = pend_q;

endmodule

// File: tb/tb_pwm_channel_controller.sv
// Directed bench for pwm_channel_controller with CLK_DIV=4 (1024-clk period).
// Update-timing scenario follows PWM_SYNC_UPDATE_EN.
module tb_pwm_channel_controller;

   logic        clk;
   logic        rst_n;
   logic [15:0] en_out;
   logic [15:0] en_pwm;
   logic [7:0]  duty;
   logic [15:0] pins;
   logic        period_start;
   logic        cfg_pending;

   int errors;
   int checks;

   pwm_channel_controller #(.CLK_DIV(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_out       (en_out),
      .en_pwm       (en_pwm),
      .duty         (duty),
      .pins         (pins),
      .period_start (period_start),
      .cfg_pending  (cfg_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns positioned on the negedge sample where period_start is high.
   task automatic wait_ps();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 2100; n++) begin
         @(negedge clk);
         if (period_start) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wait_ps: period_start got 0 required 1 within 2100 clks");
      end
   endtask

   task automatic settle();
      wait_ps();
      wait_ps();
   endtask

   task automatic test_reset();
      int n;
      int bad;
      rst_n  = 1'b0;
      en_out = '0;
      en_pwm = '0;
      duty   = '0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'hFF;
      repeat (700) @(negedge clk);
      checks++;
      if (pins !== 16'hFFFF) begin
         errors++;
         $display("FAIL pre_reset_pins: got %h required ffff", pins);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (pins !== 16'h0000) begin
         errors++;
         $display("FAIL reset_pins: got %h required 0000", pins);
      end
      checks++;
      if (cfg_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_pending: got %b required 0", cfg_pending);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pins !== 16'h0 || period_start !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_hold: bad cycles got %0d required 0", bad);
      end
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         if (period_start) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n != 1024) begin
         errors++;
         $display("FAIL first_period_start: clks got %0d required 1024", n);
      end
   endtask

   task automatic test_duty();
      int hi;
      int bad;
      en_out = 16'h0001;
      en_pwm = 16'h0001;
      duty   = 8'd128;
      settle();
      hi  = 0;
      bad = 0;
      for (int j = 0; j < 1024; j++) begin
         @(negedge clk);
         if (pins[0]) hi++;
         if (pins[15:1] !== 15'h0) bad++;
      end
      checks++;
      if (hi != 512) begin
         errors++;
         $display("FAIL duty128_high: got %0d required 512", hi);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL duty128_others: got %0d required 0", bad);
      end
   endtask

   task automatic test_extremes();
      int hi;
      int lo;
      duty = 8'd0;
      settle();
      hi = 0;
      for (int j = 0; j < 2048; j++) begin
         @(negedge clk);
         if (pins[0] !== 1'b0) hi++;
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL duty0_high: got %0d required 0", hi);
      end
      duty = 8'hFF;
      settle();
      lo = 0;
      for (int j = 0; j < 3072; j++) begin
         @(negedge clk);
         if (pins[0] !== 1'b1) lo++;
      end
      checks++;
      if (lo != 0) begin
         errors++;
         $display("FAIL duty255_low: got %0d required 0", lo);
      end
   endtask

   task automatic test_static();
      int hi8;
      int st_bad;
      int lo_bad;
      int mix;
      en_out = 16'hFF00;
      en_pwm = 16'h0F00;
      duty   = 8'd64;
      settle();
      hi8    = 0;
      st_bad = 0;
      lo_bad = 0;
      mix    = 0;
      for (int j = 0; j < 1024; j++) begin
         @(negedge clk);
         if (pins[15:12] !== 4'hF) st_bad++;
         if (pins[7:0] !== 8'h00) lo_bad++;
         if (pins[11:8] === 4'hF) hi8++;
         else if (pins[11:8] !== 4'h0) mix++;
      end
      checks++;
      if (st_bad != 0) begin
         errors++;
         $display("FAIL static_hi: bad got %0d required 0", st_bad);
      end
      checks++;
      if (lo_bad != 0) begin
         errors++;
         $display("FAIL static_off: bad got %0d required 0", lo_bad);
      end
      checks++;
      if (hi8 != 256) begin
         errors++;
         $display("FAIL static_pwm_high: got %0d required 256", hi8);
      end
      checks++;
      if (mix != 0) begin
         errors++;
         $display("FAIL static_pwm_mixed: got %0d required 0", mix);
      end
   endtask

`ifdef PWM_SYNC_UPDATE_EN
   task automatic test_update();
      int hi;
      en_out = 16'h0001;
      en_pwm = 16'h0001;
      duty   = 8'd64;
      settle();
      hi = 0;
      for (int j = 0; j < 1024; j++) begin
         if (j != 0) @(negedge clk);
         if (pins[0]) hi++;
         if (j == 399) begin
            checks++;
            if (cfg_pending !== 1'b0) begin
               errors++;
               $display("FAIL sync_pend_idle: got %b required 0", cfg_pending);
            end
         end
         if (j == 400) duty = 8'd192;
         if (j == 401 || j == 1023) begin
            checks++;
            if (cfg_pending !== 1'b1) begin
               errors++;
               $display("FAIL sync_pend_set j=%0d: got %b required 1", j, cfg_pending);
            end
         end
      end
      checks++;
      if (hi != 256) begin
         errors++;
         $display("FAIL sync_old_period: high got %0d required 256", hi);
      end
      @(negedge clk);
      checks++;
      if (period_start !== 1'b1 || cfg_pending !== 1'b0) begin
         errors++;
         $display("FAIL sync_wrap: ps/pend got %b%b required 10", period_start, cfg_pending);
      end
      hi = 0;
      for (int j = 0; j < 1024; j++) begin
         if (j != 0) @(negedge clk);
         if (pins[0]) hi++;
      end
      checks++;
      if (hi != 768) begin
         errors++;
         $display("FAIL sync_new_period: high got %0d required 768", hi);
      end
   endtask
`else
   task automatic test_update();
      int hi;
      int pend;
      en_out = 16'h0001;
      en_pwm = 16'h0001;
      duty   = 8'd64;
      settle();
      pend = 0;
      for (int j = 0; j < 1024; j++) begin
         if (j != 0) @(negedge clk);
         if (cfg_pending !== 1'b0) pend++;
         if (j == 400) begin
            checks++;
            if (pins[0] !== 1'b0) begin
               errors++;
               $display("FAIL imm_before: got %b required 0", pins[0]);
            end
            duty = 8'd192;
         end
         if (j == 402) begin
            checks++;
            if (pins[0] !== 1'b1) begin
               errors++;
               $display("FAIL imm_after: got %b required 1", pins[0]);
            end
         end
      end
      wait_ps();
      hi = 0;
      for (int j = 0; j < 1024; j++) begin
         if (j != 0) @(negedge clk);
         if (pins[0]) hi++;
         if (cfg_pending !== 1'b0) pend++;
      end
      checks++;
      if (hi != 768) begin
         errors++;
         $display("FAIL imm_new_period: high got %0d required 768", hi);
      end
      checks++;
      if (pend != 0) begin
         errors++;
         $display("FAIL imm_pending: got %0d required 0", pend);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      en_out = '0;
      en_pwm = '0;
      duty   = '0;
      test_reset();
      test_duty();
      test_extremes();
      test_static();
      test_update();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
